// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared FSM state type and index-width helper for the UART TX arbiter
package uart_tx_arb_pkg;

   typedef enum logic {IDLE, GRANT} arb_state_t;

   // Width of an index into n items; never 0 so single-bit buses stay legal
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester handshake bundle plus FIFO write port
//   req_valid/req_data/req_last : producers -> arbiter
//   req_ready                   : arbiter -> producers, byte accepted this cycle
//   fifo_d_in/fifo_w_en         : arbiter -> FIFO write port
//   fifo_full                   : FIFO -> arbiter
//   modport master = producer/FIFO side, modport slave = arbiter side
interface uart_tx_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8
);
   logic [N_REQ-1:0]            req_valid;
   logic [N_REQ-1:0][WIDTH-1:0] req_data;
   logic [N_REQ-1:0]            req_last;
   logic [N_REQ-1:0]            req_ready;
   logic [WIDTH-1:0]            fifo_d_in;
   logic                        fifo_w_en;
   logic                        fifo_full;

   modport master (
      output req_valid, req_data, req_last, fifo_full,
      input  req_ready, fifo_d_in, fifo_w_en
   );

   modport slave (
      input  req_valid, req_data, req_last, fifo_full,
      output req_ready, fifo_d_in, fifo_w_en
   );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker
//   i_valid : request vector
//   i_start : index with highest priority this cycle
//   o_idx   : first valid index at or after i_start, wrapping
//   o_any   : at least one request is valid
module rr_pick
   import uart_tx_arb_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = idx_w(N)
) (
   input  logic [N-1:0]  i_valid,
   input  logic [IW-1:0] i_start,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   // Scan from lowest priority to highest so the highest-priority hit wins last
   always_comb begin
      int j;
      j = 0;
      o_any = |i_valid;
      o_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = (int'(i_start) + k) % N;
         if (i_valid[IW'(j)]) o_idx = IW'(j);
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter sharing one FIFO write port
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : requester handshakes and FIFO write port (slave modport)
//   o_grant_id  : currently/last granted requester
//   o_busy      : a grant is active
module uart_tx_arbiter
   import uart_tx_arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   uart_tx_arbiter_if.slave         bus,
   output logic [idx_w(N_REQ)-1:0]  o_grant_id,
   output logic                     o_busy
);

   localparam int IW = idx_w(N_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);

   arb_state_t      r_state;
   arb_state_t      w_next;
   logic [IW-1:0]   r_grant;
   logic [IW-1:0]   r_last;
   logic [IW-1:0]   w_start;
   logic [IW-1:0]   w_pick;
   logic [BW-1:0]   r_cnt;
   logic            w_any;
   logic            w_xfer;
   logic            w_rel;

   assign w_start = (r_last == IW'(N_REQ - 1)) ? '0 : r_last + 1'b1;

   rr_pick #(.N(N_REQ)) u_pick (
      .i_valid (bus.req_valid),
      .i_start (w_start),
      .o_idx   (w_pick),
      .o_any   (w_any)
   );

   assign w_xfer = (r_state == GRANT) && bus.req_valid[r_grant] && !bus.fifo_full;
   // Packet end and burst limit collapse into one release
   assign w_rel  = w_xfer && (bus.req_last[r_grant] || r_cnt == BW'(MAX_BURST - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = (r_state == IDLE) ? (w_any ? GRANT : IDLE) : (w_rel ? IDLE : GRANT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_grant <= '0;
         r_last  <= IW'(N_REQ - 1);
         r_cnt   <= '0;
      end else begin
         if (r_state == IDLE && w_any) begin
            r_grant <= w_pick;
            r_cnt   <= '0;
         end else if (w_xfer) begin
            r_cnt   <= r_cnt + 1'b1;
         end
         if (w_rel) r_last <= r_grant;
      end
   end

   // Ready is offered to the granted requester whenever the FIFO has room, valid or not
   always_comb begin
      o_busy        = (r_state == GRANT);
      o_grant_id    = r_grant;
      bus.fifo_w_en = w_xfer;
      bus.fifo_d_in = o_busy ? bus.req_data[r_grant] : '0;
      bus.req_ready = (o_busy && !bus.fifo_full) ? (N_REQ'(1) << r_grant) : '0;
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table-driven and sequence checks for uart_tx_arbiter
module tb_uart_tx_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] grant_id;
   logic       busy;

   uart_tx_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();

   uart_tx_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_BURST(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .o_grant_id (grant_id),
      .o_busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] v;
      logic [3:0] l;
      logic       f;
      logic [7:0] d2;
      logic       eb;
      logic       ew;
      logic [7:0] ed;
      logic [3:0] er;
      logic [1:0] eg;
   } vec_t;

   typedef struct {
      int         id;
      logic [7:0] d;
      int         c;
   } wr_t;

   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   vec_t       vt[9];
   wr_t        wlog[$];
   wr_t        exp_log[$];
   logic [7:0] q_d[4][$];
   logic       q_l[4][$];
   logic [3:0] hold = '0;
   logic       full_now = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.req_valid = '0;
      bus.req_last = '0;
      bus.req_data = '0;
      bus.fifo_full = 1'b0;
      hold = '0;
      full_now = 1'b0;
      for (int i = 0; i < 4; i++) begin
         q_d[i].delete();
         q_l[i].delete();
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
      wlog.delete();
      exp_log.delete();
   endtask

   task automatic push(input int r, input logic [7:0] d, input logic l);
      q_d[r].push_back(d);
      q_l[r].push_back(l);
   endtask

   task automatic expect_wr(input int id, input logic [7:0] d, input int c);
      exp_log.push_back('{id, d, c});
   endtask

   // One cycle of the producer/FIFO model: drive from queues, sample, pop accepted bytes
   task automatic step();
      for (int i = 0; i < 4; i++) begin
         bus.req_valid[i] = (q_d[i].size() > 0) && !hold[i];
         bus.req_data[i]  = (q_d[i].size() > 0) ? q_d[i][0] : 8'h00;
         bus.req_last[i]  = (q_l[i].size() > 0) ? q_l[i][0] : 1'b0;
      end
      bus.fifo_full = full_now;
      #1;
      if (bus.fifo_w_en) wlog.push_back('{int'(grant_id), bus.fifo_d_in, cyc});
      if (full_now) chk("full_blocks", {27'd0, bus.fifo_w_en, bus.req_ready}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         if (bus.req_ready[i] && bus.req_valid[i]) begin
            void'(q_d[i].pop_front());
            void'(q_l[i].pop_front());
         end
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic cmp_log(input string name);
      chk({name, "_count"}, wlog.size(), exp_log.size());
      for (int i = 0; i < exp_log.size() && i < wlog.size(); i++) begin
         chk($sformatf("%s[%0d]_id", name, i), wlog[i].id, exp_log[i].id);
         chk($sformatf("%s[%0d]_data", name, i), {24'd0, wlog[i].d}, {24'd0, exp_log[i].d});
         chk($sformatf("%s[%0d]_cyc", name, i), wlog[i].c, exp_log[i].c);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      //          valid    last     full  d2     busy  wen   din    ready    gid
      vt[0] = '{4'b0100, 4'b0000, 1'b0, 8'hA1, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd0};
      vt[1] = '{4'b0100, 4'b0000, 1'b0, 8'hA1, 1'b1, 1'b1, 8'hA1, 4'b0100, 2'd2};
      vt[2] = '{4'b0100, 4'b0000, 1'b0, 8'hA2, 1'b1, 1'b1, 8'hA2, 4'b0100, 2'd2};
      vt[3] = '{4'b0100, 4'b0100, 1'b0, 8'hA3, 1'b1, 1'b1, 8'hA3, 4'b0100, 2'd2};
      vt[4] = '{4'b1000, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd2};
      vt[5] = '{4'b0000, 4'b0000, 1'b0, 8'h00, 1'b1, 1'b0, 8'hEE, 4'b1000, 2'd3};
      vt[6] = '{4'b1000, 4'b1000, 1'b1, 8'h00, 1'b1, 1'b0, 8'hEE, 4'b0000, 2'd3};
      vt[7] = '{4'b1000, 4'b1000, 1'b0, 8'h00, 1'b1, 1'b1, 8'hEE, 4'b1000, 2'd3};
      vt[8] = '{4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd3};

      do_reset();
      for (int i = 0; i < 9; i++) begin
         bus.req_valid = vt[i].v;
         bus.req_last  = vt[i].l;
         bus.fifo_full = vt[i].f;
         bus.req_data  = {8'hEE, vt[i].d2, 8'hEE, 8'hEE};
         #1;
         chk($sformatf("row%0d_busy", i), {31'd0, busy}, {31'd0, vt[i].eb});
         chk($sformatf("row%0d_wen", i), {31'd0, bus.fifo_w_en}, {31'd0, vt[i].ew});
         chk($sformatf("row%0d_din", i), {24'd0, bus.fifo_d_in}, {24'd0, vt[i].ed});
         chk($sformatf("row%0d_ready", i), {28'd0, bus.req_ready}, {28'd0, vt[i].er});
         chk($sformatf("row%0d_gid", i), {30'd0, grant_id}, {30'd0, vt[i].eg});
         @(negedge clk);
      end

      do_reset();
      for (int r = 0; r < 4; r++) begin
         push(r, 8'h40 + 8'(r), 1'b1);
         push(r, 8'h48 + 8'(r), 1'b1);
      end
      for (int k = 0; k < 8; k++) expect_wr(k % 4, (k < 4) ? 8'h40 + 8'(k) : 8'h44 + 8'(k), 2 * k + 1);
      for (int c = 0; c < 20; c++) step();
      cmp_log("fair");

      do_reset();
      for (int i = 0; i < 4; i++) push(1, 8'h10 + 8'(i), i == 3);
      expect_wr(1, 8'h10, 1);
      expect_wr(1, 8'h11, 2);
      expect_wr(1, 8'h12, 5);
      expect_wr(1, 8'h13, 6);
      for (int c = 0; c < 10; c++) begin
         full_now = (c == 3 || c == 4);
         step();
      end
      cmp_log("bp");

      do_reset();
      for (int i = 0; i < 20; i++) push(1, 8'h20 + 8'(i), 1'b0);
      push(3, 8'h99, 1'b1);
      for (int i = 0; i < 16; i++) expect_wr(1, 8'h20 + 8'(i), i + 1);
      expect_wr(3, 8'h99, 18);
      for (int i = 16; i < 20; i++) expect_wr(1, 8'h20 + 8'(i), i + 4);
      for (int c = 0; c < 30; c++) step();
      cmp_log("burst");
      chk("burst_wait_busy", {31'd0, busy}, 32'd1);
      chk("burst_wait_gid", {30'd0, grant_id}, 32'd1);

      bus.req_valid = 4'b0010;
      bus.req_data[1] = 8'h5A;
      #1;
      chk("pre_rst_wen", {31'd0, bus.fifo_w_en}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_wen", {31'd0, bus.fifo_w_en}, 32'd0);
      chk("rst_ready", {28'd0, bus.req_ready}, 32'd0);
      chk("rst_gid", {30'd0, grant_id}, 32'd0);
      chk("rst_din", {24'd0, bus.fifo_d_in}, 32'd0);

      do_reset();
      push(0, 8'h50, 1'b0);
      push(0, 8'h51, 1'b0);
      push(0, 8'h52, 1'b1);
      push(2, 8'h77, 1'b1);
      expect_wr(0, 8'h50, 1);
      expect_wr(0, 8'h51, 2);
      expect_wr(0, 8'h52, 8);
      expect_wr(2, 8'h77, 10);
      for (int c = 0; c < 15; c++) begin
         hold = (c >= 3 && c <= 7) ? 4'b0001 : 4'b0000;
         step();
         if (c >= 3 && c <= 7) chk($sformatf("stall%0d_grant", c), {29'd0, busy, grant_id}, {29'd0, 1'b1, 2'd0});
      end
      cmp_log("stall");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin packet arbiter that shares one byte FIFO write port between several producers in the UART echo design (echo path, status/banner generator, debug dump, ...). Each producer offers bytes with a valid/ready handshake and marks its last byte. The arbiter locks onto one producer until it finishes the packet or reaches a burst limit, then moves to the next. It never writes while the FIFO reports full.

## Interface
- N_REQ, 4, number of requesters (≥2)
- WIDTH, 8, data width; matches FIFO WIDTH
- MAX_BURST, 16, max bytes per grant before forced release (≥1)

- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- req_valid  input  N_REQ  requester i has a byte
- req_data  input  N_REQ×WIDTH  byte per requester (packed array)
- req_last  input  N_REQ  byte is last of packet
- req_ready  output  N_REQ  byte of requester i accepted this cycle
- fifo_d_in  output  WIDTH  to FIFO d_in
- fifo_w_en  output  1  to FIFO w_en
- fifo_full  input  1  from FIFO full
- grant_id  output  $clog2(N_REQ)  currently/last granted requester
- busy  output  1  grant active

## Operation
- States: IDLE, GRANT.
- IDLE: if any req_valid, pick the first valid index starting at (last_grant+1) mod N_REQ, wrapping. Register grant_id, clear burst count, go to GRANT. If none is valid, stay.
- GRANT: transfer = req_valid[grant_id] && !fifo_full.
  - Combinational outputs: fifo_w_en = transfer; fifo_d_in = req_data[grant_id] in GRANT, else 0.
  - req_ready[grant_id] = GRANT && !fifo_full, regardless of valid. All other ready bits are 0.
- Burst count (width $clog2(MAX_BURST+1)) increments on each transfer.
- Release to IDLE on the transfer that has req_last set, or on the transfer that makes the count equal MAX_BURST. At release, last_grant <= grant_id.
- Requester drops valid mid-packet: keep the grant and wait indefinitely; no timeout.
- fifo_full: no write and no ready that cycle; data is held by the requester; no loss, no reordering.
- A forced release without last is not remembered. The requester re-enters arbitration normally and its packet continues later; interleaving is acceptable to consumers.
- Valid bits of non-granted requesters are ignored in GRANT.

## Timing
- Reset (async assert, sync release is the system's job):
  - state IDLE, last_grant N_REQ-1 (so requester 0 wins first), grant_id 0, burst count 0.
  - busy 0, fifo_w_en 0, req_ready all 0, fifo_d_in 0.
- Arbitration latency: 1 cycle. Valid seen in IDLE at edge k means ready/w_en are possible in cycle k+1.
- Throughput: 1 byte/cycle within a grant. There is 1 idle bubble between grants (GRANT→IDLE→GRANT).
- busy = (state == GRANT), registered.
- grant_id holds its value in IDLE.
- Simultaneous last-transfer and burst-limit: a single release, same behaviour.
- Reset mid-packet: outputs go to reset values immediately. After release, arbitration restarts at requester 0.

## Structure
- Package uart_tx_arb_pkg: typedef enum logic {IDLE, GRANT} arb_state_t; helper function for the index width.
- Sub-module rr_pick: combinational round-robin picker. Inputs are a valid vector and a start index; outputs are the winner index and an any-valid flag. Parameter N.
- The top holds the FSM, burst counter, last_grant register and output muxing.

## Test plan
- Reset: assert rst_n=0 mid-run → busy=0, fifo_w_en=0, req_ready=0000, grant_id=0 with no clock edge needed.
- Single packet: req 2 sends 0xA1,0xA2,0xA3 (last on 0xA3), FIFO not full → grant next cycle, fifo_w_en high 3 consecutive cycles with those bytes, then busy=0.
- Fairness: reqs 0–3 all valid with 1-byte packets continuously → write order 0,1,2,3,0,1, with one bubble cycle between each.
- Backpressure: req 1 sends 4 bytes 0x10–0x13; fifo_full=1 for 2 cycles after the 2nd byte → w_en/ready low exactly those cycles, FIFO receives 0x10,0x11,0x12,0x13 in order.
- Burst limit: MAX_BURST=16; req 1 streams 20 bytes with no last, req 3 holds a 1-byte packet → 16 bytes from req 1, then req 3's byte, then the remaining 4 bytes from req 1.
- Stall: granted req 0 drops valid for 5 cycles mid-packet while req 2 is valid → grant stays on 0, no writes, req 2 is served only after req 0's last byte.
